// File: rtl/reflex_pkg.sv
// rtl/reflex_pkg.sv - shared state encoding and constants for the reflex round tester
package reflex_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        GO,
        HOLD,
        DONE
    } state_t;

    localparam logic [13:0] FALSE_START_CODE = 14'h3FFF;
    localparam logic [15:0] LFSR_SEED        = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10 of the state
    localparam logic [15:0] LFSR_TAPS        = 16'hB400;

endpackage

// File: rtl/reflex_lfsr.sv
// rtl/reflex_lfsr.sv - 16-bit free-running Fibonacci LFSR exposing its low bits
module reflex_lfsr
    import reflex_pkg::*;
#(
    parameter int OUT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    output logic [OUT_BITS-1:0] rnd
);

    logic [15:0] lfsr_q;
    logic        feedback;

    assign feedback = ^(lfsr_q & LFSR_TAPS);
    assign rnd      = lfsr_q[OUT_BITS-1:0];

    // Shift every cycle; the zero check keeps the register out of the lock-up state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (lfsr_q == 16'h0000) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], feedback};
        end
    end

endmodule

// File: rtl/reflex_round_tester.sv
// rtl/reflex_round_tester.sv - multi-round reflex tester; REFLEX_FALSE_START_PENALTY_EN scores false starts as rounds
module reflex_round_tester
    import reflex_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int ROUNDS       = 4,
    parameter int MIN_DELAY_MS = 1000,
    parameter int DELAY_BITS   = 12,
    parameter int TIMEOUT_MS   = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        button,
    output logic        led,
    output logic        busy,
    output logic [3:0]  round_idx,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        false_start,
    output logic        timeout,
    output logic [13:0] best_ms,
    output logic [13:0] avg_ms,
    output logic        done
);

    localparam int PRESCALE    = CLK_HZ / 1000;
    localparam int PRESC_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DELAY_W     = $clog2(MIN_DELAY_MS + (1 << DELAY_BITS));
    localparam int ROUND_SHIFT = $clog2(ROUNDS);

    localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(PRESCALE - 1);
    localparam logic [13:0]        TIMEOUT_VAL = 14'(TIMEOUT_MS);
    localparam logic [3:0]         LAST_ROUND  = 4'(ROUNDS - 1);

    state_t state, next_state;

    logic start_r, start_d, button_r, button_d;
    logic start_edge, button_edge;

    logic [PRESC_W-1:0]    presc;
    logic                  tick;
    logic [DELAY_W-1:0]    delay;
    logic [13:0]           react;
    logic [DELAY_BITS-1:0] lfsr_rnd;
    logic [17:0]           sum;
    logic                  counted;

    logic enter_arm, enter_go;
    logic fs_evt, hit_evt, to_evt;
    logic session_clr, round_next, done_evt;
    logic stat_upd;
    logic [13:0] stat_val;

    reflex_lfsr #(
        .OUT_BITS(DELAY_BITS)
    ) u_lfsr (
        .clk  (clk),
        .reset(reset),
        .rnd  (lfsr_rnd)
    );

    assign start_edge  = start_r & ~start_d;
    assign button_edge = button_r & ~button_d;
    assign tick        = (presc == PRESC_LAST);
    assign enter_arm   = (next_state == ARM) && (state != ARM);
    assign enter_go    = (next_state == GO) && (state != GO);
    assign busy        = (state == ARM) || (state == GO) || (state == HOLD);
    assign done        = (state == DONE);

    // Register the debounced levels so edges are detected on clean, local copies
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_r  <= 1'b0;
            start_d  <= 1'b0;
            button_r <= 1'b0;
            button_d <= 1'b0;
        end else begin
            start_r  <= start;
            start_d  <= start_r;
            button_r <= button;
            button_d <= button_r;
        end
    end

    // Millisecond prescaler, re-phased whenever a wait or a measurement begins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (enter_arm || enter_go || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // Random pre-LED delay countdown and reaction-time counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delay <= '0;
            react <= '0;
        end else begin
            if (enter_arm) begin
                delay <= DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_rnd);
            end else if ((state == ARM) && tick && (delay != '0)) begin
                delay <= delay - DELAY_W'(1);
            end
            if (enter_go) begin
                react <= '0;
            end else if ((state == GO) && tick) begin
                react <= react + 14'd1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and round events; a button edge always beats delay expiry or timeout
    always_comb begin
        next_state  = state;
        fs_evt      = 1'b0;
        hit_evt     = 1'b0;
        to_evt      = 1'b0;
        session_clr = 1'b0;
        round_next  = 1'b0;
        done_evt    = 1'b0;
        stat_upd    = 1'b0;
        stat_val    = '0;
        case (state)
            IDLE, DONE: begin
                if (start_edge) begin
                    next_state  = ARM;
                    session_clr = 1'b1;
                end
            end
            ARM: begin
                if (button_edge) begin
                    fs_evt     = 1'b1;
                    next_state = HOLD;
`ifdef REFLEX_FALSE_START_PENALTY_EN
                    stat_upd   = 1'b1;
                    stat_val   = TIMEOUT_VAL;
`endif
                end else if (delay == '0) begin
                    next_state = GO;
                end
            end
            GO: begin
                if (button_edge) begin
                    hit_evt    = 1'b1;
                    stat_upd   = 1'b1;
                    stat_val   = react;
                    next_state = HOLD;
                end else if (react == TIMEOUT_VAL) begin
                    to_evt     = 1'b1;
                    stat_upd   = 1'b1;
                    stat_val   = TIMEOUT_VAL;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (!button_r) begin
                    if (!counted) begin
                        next_state = ARM;
                    end else if (round_idx == LAST_ROUND) begin
                        next_state = DONE;
                        done_evt   = 1'b1;
                    end else begin
                        next_state = ARM;
                        round_next = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // LED, per-round result, flags and session statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led          <= 1'b0;
            round_idx    <= '0;
            result_ms    <= '0;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            best_ms      <= FALSE_START_CODE;
            avg_ms       <= '0;
            sum          <= '0;
            counted      <= 1'b0;
        end else begin
            result_valid <= fs_evt | hit_evt | to_evt;
            if (enter_go) begin
                led <= 1'b1;
            end else if (hit_evt || to_evt) begin
                led <= 1'b0;
            end
            if (session_clr) begin
                round_idx   <= '0;
                result_ms   <= '0;
                false_start <= 1'b0;
                timeout     <= 1'b0;
                best_ms     <= FALSE_START_CODE;
                avg_ms      <= '0;
                sum         <= '0;
                counted     <= 1'b0;
            end else begin
                if (round_next) begin
                    round_idx <= round_idx + 4'd1;
                end
                if (fs_evt) begin
`ifdef REFLEX_FALSE_START_PENALTY_EN
                    result_ms <= TIMEOUT_VAL;
                    counted   <= 1'b1;
`else
                    result_ms <= FALSE_START_CODE;
                    counted   <= 1'b0;
`endif
                    false_start <= 1'b1;
                    timeout     <= 1'b0;
                end
                if (hit_evt) begin
                    result_ms   <= react;
                    false_start <= 1'b0;
                    timeout     <= 1'b0;
                    counted     <= 1'b1;
                end
                if (to_evt) begin
                    result_ms   <= TIMEOUT_VAL;
                    false_start <= 1'b0;
                    timeout     <= 1'b1;
                    counted     <= 1'b1;
                end
                if (stat_upd) begin
                    sum <= sum + 18'(stat_val);
                    if (stat_val < best_ms) begin
                        best_ms <= stat_val;
                    end
                end
                if (done_evt) begin
                    avg_ms <= 14'(sum >> ROUND_SHIFT);
                end
            end
        end
    end

endmodule

// File: doc/reflex_round_tester.md
Name: reflex_round_tester

Overview:
- Parametrised multi-round reflex tester. On start, runs ROUNDS trials. Each trial waits a pseudo-random delay, lights the LED, and measures the button reaction time in milliseconds.
- Reports per-round result, best time and session average. Detects false starts and timeouts.
- Sits between the debounced button/start inputs and the 7-segment display formatter. Binary outputs only; display encoding lives elsewhere.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency; ms prescale = CLK_HZ/1000.
- ROUNDS, 4, trials per session; power of 2, range 1..16.
- MIN_DELAY_MS, 1000, minimum random wait before LED.
- DELAY_BITS, 12, random part width; extra delay 0..2^DELAY_BITS-1 ms.
- TIMEOUT_MS, 9999, max reaction time; must be < 16383.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, debounced level; rising edge starts a session.
- button, input, 1, debounced level; rising edge is the reaction.
- led, output, 1, stimulus LED.
- busy, output, 1, high while a session is running.
- round_idx, output, 4, index of the current/last round (0-based).
- result_ms, output, 14, last round result.
- result_valid, output, 1, one-cycle pulse when result_ms updates.
- false_start, output, 1, sticky flag for the last result.
- timeout, output, 1, sticky flag for the last result.
- best_ms, output, 14, minimum valid result this session.
- avg_ms, output, 14, session average.
- done, output, 1, high in DONE.

Behaviour:
- Reset is asynchronous and active-high: the block goes to IDLE. Every output resets to 0, except best_ms, which resets to 14'h3FFF. LFSR seeds to 16'hACE1.
- Edges: start and button are registered once; edge = current & ~previous. Held levels never trigger.
- ms tick: prescaler counts 0..CLK_HZ/1000-1 and pulses tick at the terminal count. The prescaler clears on entry to ARM and GO.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk, never all-zero.
- IDLE: start edge -> clear stats, round_idx=0, go to ARM.
- ARM: on entry, delay = MIN_DELAY_MS + lfsr[DELAY_BITS-1:0]. The delay decrements on tick.
  - delay reaches 0 -> GO; led=1 from the next cycle.
  - button edge -> false start: result_ms=14'h3FFF, false_start=1, result_valid pulse, then HOLD. This includes an edge in the same cycle the delay expires; the button wins.
- GO: react counter increments on tick.
  - button edge -> result_ms=react count (truncated ms), led=0, result_valid pulse next cycle, then HOLD.
  - react count == TIMEOUT_MS -> result_ms=TIMEOUT_MS, timeout=1, led=0, then HOLD.
  - Button edge and timeout in the same cycle: button wins.
- HOLD: wait for button low.
  - If the round counted: round_idx+1, or DONE when round_idx==ROUNDS-1.
  - Otherwise: re-enter ARM with the same round_idx.
- Stats: valid and timeout rounds update the sum (18 bits) and best = min(best, result). False starts never update stats.
- DONE: avg_ms = sum >> log2(ROUNDS), valid on entry. done=1. A start edge begins a new session; outputs hold until then.
- start edges outside IDLE/DONE are ignored. Reset mid-session aborts immediately with no partial stats.

Optional Feature:
- REFLEX_FALSE_START_PENALTY_EN.
- Defined: a false start counts as a round. result_ms=TIMEOUT_MS is added to sum/best, false_start=1, round_idx advances.
- Undefined: the round is repeated as described above.

Decomposition:
- Package reflex_pkg: state enum (IDLE, ARM, GO, HOLD, DONE), FALSE_START_CODE=14'h3FFF, LFSR_SEED, LFSR tap constant.
- Sub-module reflex_lfsr: 16-bit free-running LFSR with async reset to the seed.
- Prescaler, FSM and stats stay in the top module.

Test Plan:
- Bench config: CLK_HZ=10_000 (10 clk/ms), ROUNDS=4, MIN_DELAY_MS=5, DELAY_BITS=3, TIMEOUT_MS=50.
- Nominal: start, then press button 120 clk after led rises -> result_ms=12 with a result_valid pulse.
  - Four rounds of 12,20,8,40 -> best_ms=8, avg_ms=20, done=1.
- False start: press during ARM.
  - Without the macro: result_ms=16383, false_start=1, round_idx unchanged, round re-armed.
  - With the macro: result_ms=50, round_idx+1.
- Timeout: no press -> led drops after 500 clk, result_ms=50, timeout=1, counted in avg.
- Simultaneous: button edge in the same cycle as the delay expiry -> false start.
  - Button edge in the same cycle as the timeout -> result_ms=50, timeout=0.
- Robustness: button held from IDLE through ARM -> no false start.
  - Reset asserted mid-GO -> led=0, busy=0, best_ms=16383 asynchronously, before the next clk edge.
